uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single UART transmitter between four byte-stream requesters (command responder, status reporter, echo path, debug). It sits between the requesters and the UART TX core. It grants one requester at a time, holds that grant for a whole packet, issues one byte per transmitter cycle, and releases the grant on the last byte or on a watchdog timeout.

## Interface
Parameters:
- CLKS_PER_BIT, 868, UART bit period in i_clk cycles (100 MHz / 115200).
- TIMEOUT_CLKS, 12*CLKS_PER_BIT, watchdog limit per byte phase.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; one clock; synchronous, active-high.
- i_req_valid  in  4  per-requester byte valid.
- i_req_data  in  32  packed bytes; requester k uses bits [8k+7:8k].
- i_req_last  in  4  the byte offered is the last byte of its packet.
- o_req_ready  out  4  byte accepted this cycle (combinational).
- o_grant  out  4  one-hot current owner, registered.
- o_busy  out  1  a grant is held.
- o_err  out  1  one-cycle pulse on watchdog release.
- o_TX_DV  out  1  one-cycle load strobe to the transmitter.
- o_TX_Byte  out  8  byte to the transmitter; valid while o_TX_DV=1.
- i_TX_Active  in  1  transmitter is shifting.
- i_TX_Done  in  1  one-cycle pulse after the stop bit.

## Operation
- Reset values: state IDLE, rr pointer ptr=0, o_grant=0, o_busy=0, o_err=0, o_TX_DV=0, o_TX_Byte=0, o_req_ready=0, watchdog count=0.
- **IDLE**
  - Select the first k with i_req_valid[k]=1, scanning ptr, ptr+1, … mod 4.
  - Register o_grant=onehot(k) and o_busy=1, then go to SEND.
  - With no valid requester, remain in IDLE.
- **SEND**
  - o_req_ready[g] = i_req_valid[g] & ~i_TX_Active. This is the handshake cycle.
  - On the handshake, register o_TX_Byte=data[g], o_TX_DV=1 (next cycle only), and last_q=i_req_last[g]. Then go to WAIT with the watchdog cleared.
  - While no handshake occurs, the watchdog counts up.
- **WAIT**
  - The watchdog counts every cycle; i_TX_Done is ignored in the cycle o_TX_DV=1.
  - On i_TX_Done with last_q=1: release, meaning o_grant=0, o_busy=0, ptr=g+1 mod 4, then go to IDLE.
  - On i_TX_Done with last_q=0: go to SEND with the watchdog cleared.
- **Watchdog**
  - When the count reaches TIMEOUT_CLKS-1 in SEND or WAIT, pulse o_err for one cycle, release as above, and go to IDLE.
  - Counter width is clog2(TIMEOUT_CLKS+1). The counter saturates and never wraps.
- Only the granted requester ever sees ready. Valid from other requesters is ignored until release.

## Timing
- Valid seen in IDLE at cycle t: o_grant set at t+1, handshake possible at t+1, o_TX_DV at t+2.
- Between bytes of a packet, the next handshake is no earlier than the cycle after i_TX_Done.
- Back-to-back packets: release at cycle r, new grant at r+2 (one IDLE cycle).
- Simultaneous events:
  - i_TX_Done and watchdog expiry in the same cycle: Done wins, no o_err.
  - Release and a new valid in the same cycle: arbitration uses the updated ptr.
- Reset mid-packet:
  - All outputs return to reset values the next cycle, and o_TX_DV is forced low.
  - A byte already in the transmitter completes on its own. The i_TX_Done that follows in IDLE is ignored.
- ptr wraps 3→0.

## Test plan
- **Single byte:** req1 offers 0x56 with last=1 → grant=0010 one cycle later; one o_TX_DV with o_TX_Byte=0x56; grant clears after i_TX_Done; the next winner starts scanning at 2.
- **Four-way contention** after reset: single-byte packets 0x48, 0x49, 0x4A, 0x4B on req0–3 → bytes transmitted in order 0x48, 0x49, 0x4A, 0x4B; o_err stays 0.
- **Packet lock:** req0 sends 0x48, 0x69, 0x0A (last on 0x0A) while req2 holds 0x56 valid → req2 gets no ready until after the 0x0A Done; then 0x56 is sent.
- **Watchdog in WAIT:** the transmitter model never pulses Done → o_err pulses exactly TIMEOUT_CLKS cycles after entering WAIT; grant releases and the next requester is served.
- **Watchdog in SEND:** req3 drops valid after the first of two bytes → grant held, o_err after TIMEOUT_CLKS, ptr=0.
- **Reset mid-packet:** i_rst is asserted in WAIT of the second byte → the next cycle shows grant=0, busy=0, TX_DV=0; the stray Done is ignored; the following request is served from ptr=0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter bus of the UART TX arbiter.
// slave: the arbiter side. master: the requesters plus the TX core side.
interface uart_tx_arbiter_if;
  logic [3:0]  i_req_valid;
  logic [31:0] i_req_data;
  logic [3:0]  i_req_last;
  logic [3:0]  o_req_ready;
  logic [3:0]  o_grant;
  logic        o_busy;
  logic        o_err;
  logic        o_TX_DV;
  logic [7:0]  o_TX_Byte;
  logic        i_TX_Active;
  logic        i_TX_Done;

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_TX_Active, i_TX_Done,
    output o_req_ready, o_grant, o_busy, o_err, o_TX_DV, o_TX_Byte
  );

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_TX_Active, i_TX_Done,
    input  o_req_ready, o_grant, o_busy, o_err, o_TX_DV, o_TX_Byte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the single UART transmitter across four byte streams.
// A grant is held for a whole packet; the watchdog frees a stuck owner.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 12 * CLKS_PER_BIT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CLKS - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CLKS);

  // A watchdog shorter than one 10-bit frame would kill every healthy byte.
  if (TIMEOUT_CLKS < 10 * CLKS_PER_BIT) begin : g_bad_timeout
    $error("TIMEOUT_CLKS shorter than one UART frame");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      gidx_q, gidx_d;
  logic [3:0]      grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            dv_q, dv_d;
  logic            last_q, last_d;
  logic [7:0]      byte_q, byte_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic [1:0] pick, cand;
  logic       pick_vld;
  logic [3:0] ready;
  logic       hs, wd_hit, rel;

  // Round-robin scan: walk from ptr+3 down to ptr so the closest-to-ptr valid wins.
  always_comb begin
    pick     = ptr_q;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (bus.i_req_valid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Only the owner in SEND may hand over a byte, and only while the TX core is idle.
  always_comb begin
    ready = '0;
    if (state_q == ST_SEND) ready[gidx_q] = bus.i_req_valid[gidx_q] & ~bus.i_TX_Active;
  end

  assign hs     = |ready;
  assign wd_hit = (wd_q == WD_LAST);

  // Next-state: grant, handshake, wait for Done, watchdog release.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    last_d  = last_q;
    wd_d    = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
    rel     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (pick_vld) begin
          gidx_d  = pick;
          grant_d = 4'b0001 << pick;
          busy_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs) begin
          byte_d  = bus.i_req_data[{gidx_q, 3'b000} +: 8];
          dv_d    = 1'b1;
          last_d  = bus.i_req_last[gidx_q];
          wd_d    = '0;
          state_d = ST_WAIT;
        end else if (wd_hit) begin
          rel   = 1'b1;
          err_d = 1'b1;
        end
      end
      ST_WAIT: begin
        // Done in the load cycle belongs to an earlier byte, so it is ignored.
        if (bus.i_TX_Done && !dv_q) begin
          if (last_q) begin
            rel = 1'b1;
          end else begin
            state_d = ST_SEND;
            wd_d    = '0;
          end
        end else if (wd_hit) begin
          rel   = 1'b1;
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rel) begin
      grant_d = '0;
      busy_d  = 1'b0;
      ptr_d   = gidx_q + 2'd1;
      wd_d    = '0;
      state_d = ST_IDLE;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
      byte_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
      byte_q  <= byte_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.o_req_ready = ready;
  assign bus.o_grant     = grant_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_err       = err_q;
  assign bus.o_TX_DV     = dv_q;
  assign bus.o_TX_Byte   = byte_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a TX core model, a
// per-cycle reference model of the arbiter, and directed scenario checks.
module tb_uart_tx_arbiter;
  localparam int CPB   = 2;
  localparam int T     = 24;        // 12 * CPB
  localparam int FRAME = 10 * CPB;  // TX core busy time per byte

  logic clk, rst;
  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(T)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_errs = 0;
  int cyc = 0;

  // requester byte queues: {last, data}
  logic [8:0] rq [4][$];
  logic       rst_req = 1'b1;
  bit         tx_mute = 1'b0;
  int         tx_cnt  = 0;
  bit         dv_seen = 1'b0;

  logic [7:0] tx_log[$];
  int         dv_cyc_q[$], err_cyc_q[$], done_cyc_q[$];

  // reference model state (describes the current cycle)
  int         m_owner = -1, m_ptr = 0, m_wd = 0;
  bit         m_flight = 0, m_last = 0, m_err = 0, m_dv = 0, m_rel, m_was_dv;
  logic [7:0] m_byte = '0;
  logic [3:0] exp_rdy, exp_grant;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic chk_log(input string nm, input int n, input logic [31:0] exp);
    chk({nm, "_count"}, tx_log.size(), n);
    for (int i = 0; i < n; i++)
      if (i < tx_log.size()) chk(nm, tx_log[i], exp[8*(n-1-i) +: 8]);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((bus.o_busy || rq[0].size() || rq[1].size() || rq[2].size() || rq[3].size()
            || tx_cnt != 0) && n < 2000) begin
      tick(1);
      n++;
    end
    chk({nm, "_timeout"}, (n >= 2000), 0);
    tick(2);
  endtask

  task automatic clear_logs();
    tx_log.delete(); dv_cyc_q.delete(); err_cyc_q.delete(); done_cyc_q.delete();
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    tick(2);
    rst_req = 1'b0;
    tick(1);
  endtask

  // Driver, TX core model, per-cycle compare and reference model.
  initial begin
    logic [3:0]  v, l;
    logic [31:0] d;
    logic [8:0]  hd;
    rst = 1'b1;
    bus.i_req_valid = '0; bus.i_req_data = '0; bus.i_req_last = '0;
    bus.i_TX_Active = 1'b0; bus.i_TX_Done = 1'b0;
    forever begin
      @(posedge clk); #1;
      rst = rst_req;
      bus.i_TX_Done = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          bus.i_TX_Active = 1'b0;
          bus.i_TX_Done   = !tx_mute;
        end
      end
      if (dv_seen) begin
        tx_cnt = FRAME;
        bus.i_TX_Active = 1'b1;
      end
      v = '0; l = '0; d = '0;
      for (int k = 0; k < 4; k++) begin
        if (rq[k].size() > 0) begin
          hd = rq[k][0];
          v[k] = 1'b1;
          l[k] = hd[8];
          d[8*k +: 8] = hd[7:0];
        end
      end
      bus.i_req_valid = v; bus.i_req_last = l; bus.i_req_data = d;

      @(negedge clk);
      cyc++;
      dv_seen = bus.o_TX_DV;

      // what this cycle must look like
      exp_rdy = '0;
      exp_grant = '0;
      if (m_owner >= 0) begin
        exp_grant[m_owner] = 1'b1;
        if (!m_flight) exp_rdy[m_owner] = bus.i_req_valid[m_owner] & ~bus.i_TX_Active;
      end
      chk("cycle_outputs",
          {bus.o_grant, bus.o_busy, bus.o_err, bus.o_TX_DV, bus.o_req_ready},
          {exp_grant, (m_owner >= 0), m_err, m_dv, exp_rdy});
      if (m_dv) chk("cycle_tx_byte", bus.o_TX_Byte, m_byte);

      if (bus.o_TX_DV) begin tx_log.push_back(bus.o_TX_Byte); dv_cyc_q.push_back(cyc); end
      if (bus.o_err) err_cyc_q.push_back(cyc);
      if (bus.i_TX_Done) done_cyc_q.push_back(cyc);
      for (int k = 0; k < 4; k++)
        if (bus.o_req_ready[k] && bus.i_req_valid[k] && rq[k].size() > 0) void'(rq[k].pop_front());

      // advance the model across the coming edge
      if (rst) begin
        m_owner = -1; m_ptr = 0; m_wd = 0; m_flight = 0; m_last = 0;
        m_err = 0; m_dv = 0; m_byte = '0;
      end else begin
        m_rel = 0; m_was_dv = m_dv;
        m_err = 0; m_dv = 0;
        if (m_owner < 0) begin
          for (int i = 0; i < 4; i++)
            if (m_owner < 0 && bus.i_req_valid[(m_ptr + i) % 4]) m_owner = (m_ptr + i) % 4;
          m_flight = 0; m_wd = 0;
        end else if (!m_flight) begin
          if (exp_rdy[m_owner]) begin
            m_dv = 1; m_byte = bus.i_req_data[8*m_owner +: 8];
            m_last = bus.i_req_last[m_owner]; m_flight = 1; m_wd = 0;
          end else if (m_wd == T - 1) begin
            m_rel = 1; m_err = 1;
          end else m_wd++;
        end else begin
          if (bus.i_TX_Done && !m_was_dv) begin
            if (m_last) m_rel = 1;
            else begin m_flight = 0; m_wd = 0; end
          end else if (m_wd == T - 1) begin
            m_rel = 1; m_err = 1;
          end else m_wd++;
        end
        if (m_rel) begin m_ptr = (m_owner + 1) % 4; m_owner = -1; end
      end
    end
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    int n;
    tick(3);
    rst_req = 1'b0;
    tick(1);
    // reset state
    chk("rst_grant", bus.o_grant, 4'b0000);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_dv", bus.o_TX_DV, 0);
    chk("rst_byte", bus.o_TX_Byte, 8'h00);
    chk("rst_ready", bus.o_req_ready, 4'b0000);

    // single byte on req1
    clear_logs();
    rq[1].push_back({1'b1, 8'h56});
    tick(1);
    chk("single_grant_t", bus.o_grant, 4'b0000);
    tick(1);
    chk("single_grant_t1", bus.o_grant, 4'b0010);
    chk("single_ready_t1", bus.o_req_ready, 4'b0010);
    tick(1);
    chk("single_dv_t2", bus.o_TX_DV, 1);
    chk("single_byte_t2", bus.o_TX_Byte, 8'h56);
    wait_idle("single");
    chk("single_grant_released", bus.o_grant, 4'b0000);
    // next scan starts at 2
    clear_logs();
    rq[0].push_back({1'b1, 8'hA0});
    rq[1].push_back({1'b1, 8'hA1});
    rq[2].push_back({1'b1, 8'hA2});
    tick(2);
    chk("scan_from2_grant", bus.o_grant, 4'b0100);
    wait_idle("scan_from2");
    chk_log("scan_from2_order", 3, 32'h00A2A0A1);

    // four-way contention after reset
    do_reset();
    clear_logs();
    for (int k = 0; k < 4; k++) rq[k].push_back({1'b1, 8'h48 + 8'(k)});
    wait_idle("four_way");
    chk_log("four_way_order", 4, 32'h48494A4B);
    chk("four_way_err", err_cyc_q.size(), 0);

    // packet lock: req2 waits for req0's whole packet
    clear_logs();
    rq[0].push_back({1'b0, 8'h48});
    rq[0].push_back({1'b0, 8'h69});
    rq[0].push_back({1'b1, 8'h0A});
    rq[2].push_back({1'b1, 8'h56});
    wait_idle("lock");
    chk_log("lock_order", 4, 32'h48690A56);
    chk("lock_err", err_cyc_q.size(), 0);

    // watchdog in WAIT: no Done ever arrives
    clear_logs();
    tx_mute = 1'b1;
    rq[1].push_back({1'b1, 8'h11});
    rq[2].push_back({1'b1, 8'h22});
    wait_idle("wd_wait");
    tx_mute = 1'b0;
    chk_log("wd_wait_order", 2, 32'h00001122);
    chk("wd_wait_err_count", err_cyc_q.size(), 2);
    if (err_cyc_q.size() > 0 && dv_cyc_q.size() > 0)
      chk("wd_wait_err_delay", err_cyc_q[0] - dv_cyc_q[0], T);

    // watchdog in SEND: req3 stops after first of two bytes
    clear_logs();
    rq[3].push_back({1'b0, 8'h33});
    wait_idle("wd_send");
    chk("wd_send_err_count", err_cyc_q.size(), 1);
    if (err_cyc_q.size() > 0 && done_cyc_q.size() > 0)
      chk("wd_send_err_delay", err_cyc_q[0] - done_cyc_q[0], T + 1);
    clear_logs();
    rq[0].push_back({1'b1, 8'h44});
    rq[3].push_back({1'b1, 8'h55});
    wait_idle("wd_send_ptr");
    chk_log("wd_send_ptr0_order", 2, 32'h00004455);

    // reset during WAIT of the second byte
    clear_logs();
    rq[1].push_back({1'b0, 8'h61});
    rq[1].push_back({1'b0, 8'h62});
    rq[1].push_back({1'b1, 8'h63});
    n = 0;
    while (dv_cyc_q.size() < 2 && n < 500) begin tick(1); n++; end
    chk("midrst_second_byte_timeout", (n >= 500), 0);
    rst_req = 1'b1;
    rq[1].delete();
    tick(1);
    rst_req = 1'b0;
    tick(1);
    chk("midrst_grant", bus.o_grant, 4'b0000);
    chk("midrst_busy", bus.o_busy, 0);
    chk("midrst_dv", bus.o_TX_DV, 0);
    chk("midrst_ready", bus.o_req_ready, 4'b0000);
    tick(FRAME + 5);
    chk("midrst_stray_done_seen", done_cyc_q.size(), 2);
    chk("midrst_idle_after_stray", bus.o_busy, 0);
    clear_logs();
    rq[0].push_back({1'b1, 8'h70});
    rq[3].push_back({1'b1, 8'h73});
    wait_idle("midrst_after");
    chk_log("midrst_ptr0_order", 2, 32'h00007073);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
